// File: rtl/id_ex_pipe.sv
// ID->EX elastic pipeline register (main + skid entry); optional perf counters under `ID_EX_PERF_EN`.
// Latency: 1 cycle from accept to out_valid; full throughput while out_ready stays high.
// Backpressure: in_ready = ~skid_valid (registered); one instruction is absorbed by the skid when out_ready drops.
module id_ex_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        ctrl_in,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] rs_val_in,
    input  logic [DATA_W-1:0] rd_val_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        ctrl_out,
    output logic [OP_W-1:0]   op_out,
    output logic [DATA_W-1:0] rs_val_out,
    output logic [DATA_W-1:0] rd_val_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rd_out
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    // One decoded instruction as carried through the stage.
    typedef struct packed {
        logic [5:0]        ctrl;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rd_val;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rd;
    } ent_t;

    ent_t r_main_dat;
    ent_t r_skid_dat;
    logic r_main_vld;
    logic r_skid_vld;

    ent_t w_in_dat;
    logic w_accept;
    logic w_xfer;
    logic w_load_main;
    logic w_load_skid;

    assign w_in_dat = '{
        ctrl:   ctrl_in,
        op:     op_in,
        rs_val: rs_val_in,
        rd_val: rd_val_in,
        imm:    imm_in,
        rs:     rs_in,
        rd:     rd_in
    };

    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
    assign w_accept    = in_valid & ~r_skid_vld & ~flush;
    assign w_xfer      = r_main_vld & out_ready;
    // New data goes to main when main is empty or being drained this edge (and the skid is not refilling it).
    assign w_load_main = w_accept & (~r_main_vld | w_xfer);
    // New data goes to the skid only when main is held.
    assign w_load_skid = w_accept & r_main_vld & ~w_xfer;

    // Valid bits: flush wins; on transfer the skid (if any) or the new input refills main.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_xfer) begin
            r_main_vld <= r_skid_vld | w_accept;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld) begin
            r_main_vld <= w_accept;
        end else if (w_load_skid) begin
            r_skid_vld <= 1'b1;
        end
    end

    // Main data: skid moves forward first to keep program order, otherwise take the new input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_dat <= '0;
        end else if (!flush) begin
            if (w_xfer && r_skid_vld) begin
                r_main_dat <= r_skid_dat;
            end else if (w_load_main) begin
                r_main_dat <= w_in_dat;
            end
        end
    end

    // Skid data: captures the one instruction that arrives while main is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_dat <= '0;
        end else if (!flush && w_load_skid) begin
            r_skid_dat <= w_in_dat;
        end
    end

    assign in_ready   = ~r_skid_vld;
    assign out_valid  = r_main_vld;
    // Bubbles must not write memory/registers downstream, so control is masked; data just holds.
    assign ctrl_out   = r_main_vld ? r_main_dat.ctrl : 6'b0;
    assign op_out     = r_main_dat.op;
    assign rs_val_out = r_main_dat.rs_val;
    assign rd_val_out = r_main_dat.rd_val;
    assign imm_out    = r_main_dat.imm;
    assign rs_out     = r_main_dat.rs;
    assign rd_out     = r_main_dat.rd;

`ifdef ID_EX_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;
    logic        w_stall;
    logic        w_bubble;

    assign w_stall  = r_main_vld & ~out_ready;
    assign w_bubble = ~r_main_vld;

    // Saturating stall counter: EX holds a valid instruction but is not consuming it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if (flush) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Saturating bubble counter: EX holds nothing this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= 16'd0;
        end else if (flush) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table, async reset, wide-parameter instance, random vs. queue model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven by table rows and randomly.
module tb_id_ex_pipe;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] ctrl_in;
    logic [2:0] op_in;
    logic [7:0] rs_val_in;
    logic [7:0] rd_val_in;
    logic [7:0] imm_in;
    logic [2:0] rs_in;
    logic [2:0] rd_in;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] ctrl_out;
    logic [2:0] op_out;
    logic [7:0] rs_val_out;
    logic [7:0] rd_val_out;
    logic [7:0] imm_out;
    logic [2:0] rs_out;
    logic [2:0] rd_out;
`ifdef ID_EX_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
    logic [15:0] w2_stall_cnt;
    logic [15:0] w2_bubble_cnt;
`endif

    // Second instance with wide parameters.
    logic        w2_in_valid;
    logic        w2_in_ready;
    logic [5:0]  w2_ctrl_in;
    logic [2:0]  w2_op_in;
    logic [15:0] w2_rs_val_in;
    logic [15:0] w2_rd_val_in;
    logic [15:0] w2_imm_in;
    logic [3:0]  w2_rs_in;
    logic [3:0]  w2_rd_in;
    logic        w2_out_valid;
    logic [5:0]  w2_ctrl_out;
    logic [2:0]  w2_op_out;
    logic [15:0] w2_rs_val_out;
    logic [15:0] w2_rd_val_out;
    logic [15:0] w2_imm_out;
    logic [3:0]  w2_rs_out;
    logic [3:0]  w2_rd_out;

    id_ex_pipe u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .op_in(op_in),
        .rs_val_in(rs_val_in), .rd_val_in(rd_val_in), .imm_in(imm_in),
        .rs_in(rs_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .op_out(op_out),
        .rs_val_out(rs_val_out), .rd_val_out(rd_val_out), .imm_out(imm_out),
        .rs_out(rs_out), .rd_out(rd_out)
`ifdef ID_EX_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    id_ex_pipe #(.DATA_W(16), .REG_W(4), .OP_W(3)) u_wide (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(w2_in_valid), .in_ready(w2_in_ready),
        .ctrl_in(w2_ctrl_in), .op_in(w2_op_in),
        .rs_val_in(w2_rs_val_in), .rd_val_in(w2_rd_val_in), .imm_in(w2_imm_in),
        .rs_in(w2_rs_in), .rd_in(w2_rd_in),
        .out_valid(w2_out_valid), .out_ready(1'b1),
        .ctrl_out(w2_ctrl_out), .op_out(w2_op_out),
        .rs_val_out(w2_rs_val_out), .rd_val_out(w2_rd_val_out), .imm_out(w2_imm_out),
        .rs_out(w2_rs_out), .rd_out(w2_rd_out)
`ifdef ID_EX_PERF_EN
        , .stall_cnt(w2_stall_cnt), .bubble_cnt(w2_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of depth two.
    typedef struct {
        logic [5:0] ctrl;
        logic [2:0] op;
        logic [7:0] rsv;
        logic [7:0] rdv;
        logic [7:0] imm;
        logic [2:0] rs;
        logic [2:0] rd;
    } ent_t;

    ent_t q[$];
    ent_t last;
    int   m_stall;
    int   m_bubble;

    task automatic model_reset();
        q.delete();
        last     = '{6'd0, 3'd0, 8'd0, 8'd0, 8'd0, 3'd0, 3'd0};
        m_stall  = 0;
        m_bubble = 0;
    endtask

    // Advance the model by one edge using the inputs now applied, then wait for the DUT edge.
    task automatic tick();
        ent_t e;
        bit   ov;
        bit   ir;
        e  = '{ctrl_in, op_in, rs_val_in, rd_val_in, imm_in, rs_in, rd_in};
        ov = (q.size() > 0);
        ir = (q.size() < 2);
        if (flush) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (ov && !out_ready && m_stall < 65535) m_stall++;
            if (!ov && m_bubble < 65535) m_bubble++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && ir) q.push_back(e);
        end
        if (q.size() > 0) last = q[0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        bit ov;
        ov = (q.size() > 0);
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, ov});
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
        chk("m_ctrl", {26'd0, ctrl_out}, ov ? {26'd0, last.ctrl} : 32'd0);
        chk("m_op", {29'd0, op_out}, {29'd0, last.op});
        chk("m_rsv", {24'd0, rs_val_out}, {24'd0, last.rsv});
        chk("m_rdv", {24'd0, rd_val_out}, {24'd0, last.rdv});
        chk("m_imm", {24'd0, imm_out}, {24'd0, last.imm});
        chk("m_rs", {29'd0, rs_out}, {29'd0, last.rs});
        chk("m_rd", {29'd0, rd_out}, {29'd0, last.rd});
`ifdef ID_EX_PERF_EN
        chk("m_stall", {16'd0, stall_cnt}, m_stall);
        chk("m_bubble", {16'd0, bubble_cnt}, m_bubble);
`endif
    endtask

    // Drive the main DUT; all data fields derive from op.
    task automatic drive(input bit fl, input bit iv, input bit ordy, input logic [2:0] op);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        op_in     = op;
        ctrl_in   = {op, ~op};
        rs_val_in = {5'd0, op} + 8'd16;
        rd_val_in = {5'd0, op} + 8'd32;
        imm_in    = {5'd0, op} + 8'd64;
        rs_in     = op;
        rd_in     = ~op;
    endtask

    typedef struct {
        bit         fl;
        bit         iv;
        bit         ordy;
        logic [2:0] op;
        bit         e_ov;
        bit         e_ir;
        logic [2:0] e_op;
    } vec_t;

    function automatic vec_t mk(bit fl, bit iv, bit ordy, logic [2:0] op, bit e_ov, bit e_ir, logic [2:0] e_op);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.op = op;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_op = e_op;
        return v;
    endfunction

    vec_t vt[17];

    initial begin
        // Streaming 1,2,3
        vt[0]  = mk(0, 1, 1, 3'd1, 1, 1, 3'd1);
        vt[1]  = mk(0, 1, 1, 3'd2, 1, 1, 3'd2);
        vt[2]  = mk(0, 1, 1, 3'd3, 1, 1, 3'd3);
        vt[3]  = mk(0, 0, 1, 3'd0, 0, 1, 3'd3);
        // Backpressure: A=4 held, B=5 to skid, C=6 refused, then drain in order
        vt[4]  = mk(0, 1, 0, 3'd4, 1, 1, 3'd4);
        vt[5]  = mk(0, 1, 0, 3'd5, 1, 0, 3'd4);
        vt[6]  = mk(0, 1, 0, 3'd6, 1, 0, 3'd4);
        vt[7]  = mk(0, 1, 1, 3'd6, 1, 1, 3'd5);
        vt[8]  = mk(0, 1, 1, 3'd6, 1, 1, 3'd6);
        vt[9]  = mk(0, 0, 1, 3'd0, 0, 1, 3'd6);
        // Flush with main and skid full and in_valid high
        vt[10] = mk(0, 1, 0, 3'd1, 1, 1, 3'd1);
        vt[11] = mk(0, 1, 0, 3'd2, 1, 0, 3'd1);
        vt[12] = mk(1, 1, 0, 3'd7, 0, 1, 3'd1);
        vt[13] = mk(0, 0, 1, 3'd0, 0, 1, 3'd1);
        // Flush with only main full and in_valid high
        vt[14] = mk(0, 1, 1, 3'd3, 1, 1, 3'd3);
        vt[15] = mk(1, 1, 0, 3'd5, 0, 1, 3'd3);
        vt[16] = mk(0, 0, 1, 3'd0, 0, 1, 3'd3);

        reset = 1'b0;
        drive(0, 0, 1, 3'd0);
        w2_in_valid  = 1'b0;
        w2_ctrl_in   = 6'd0;
        w2_op_in     = 3'd0;
        w2_rs_val_in = 16'd0;
        w2_rd_val_in = 16'd0;
        w2_imm_in    = 16'd0;
        w2_rs_in     = 4'd0;
        w2_rd_in     = 4'd0;
        model_reset();
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {26'd0, ctrl_out}, 32'd0);
        chk("rst_imm", {24'd0, imm_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Wide-parameter instance: data passes unchanged after one cycle.
        w2_in_valid = 1'b1;
        w2_imm_in   = 16'hBEEF;
        w2_rd_in    = 4'hA;
        w2_ctrl_in  = 6'b010010;
        tick();
        chk("wide_valid", {31'd0, w2_out_valid}, 32'd1);
        chk("wide_imm", {16'd0, w2_imm_out}, 32'h0000BEEF);
        chk("wide_rd", {28'd0, w2_rd_out}, 32'hA);
        chk("wide_ctrl", {26'd0, w2_ctrl_out}, 32'b010010);
        w2_in_valid = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].fl, vt[i].iv, vt[i].ordy, vt[i].op);
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_ov});
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].e_ir});
            chk($sformatf("vec%0d_op", i), {29'd0, op_out}, {29'd0, vt[i].e_op});
            chk($sformatf("vec%0d_ctrl", i), {26'd0, ctrl_out},
                vt[i].e_ov ? {26'd0, vt[i].e_op, ~vt[i].e_op} : 32'd0);
        end

        // Asynchronous reset mid-cycle with a valid instruction held.
        drive(0, 1, 0, 3'd0);
        ctrl_in = 6'b100001;
        imm_in  = 8'hA5;
        tick();
        chk("pre_rst_ctrl", {26'd0, ctrl_out}, 32'b100001);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        drive(0, 1, 0, 3'd2);
        tick();
        chk("pre_rst_skid_full", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ctrl", {26'd0, ctrl_out}, 32'd0);
        chk("arst_imm", {24'd0, imm_out}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 1, 3'd2);
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_op", {29'd0, op_out}, 32'd2);
        drive(0, 0, 1, 3'd0);
        tick();

        // Randomised traffic against the FIFO model.
        for (int n = 0; n < 600; n++) begin
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ctrl_in   = 6'($urandom);
            op_in     = 3'($urandom);
            rs_val_in = 8'($urandom);
            rd_val_in = 8'($urandom);
            imm_in    = 8'($urandom);
            rs_in     = 3'($urandom);
            rd_in     = 3'($urandom);
            tick();
            check_model();
        end

`ifdef ID_EX_PERF_EN
        // Counters: 5 stalled cycles and 3 empty cycles after a flush.
        drive(1, 0, 1, 3'd0);
        tick();
        drive(0, 1, 0, 3'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 3'd0);
            tick();
        end
        drive(0, 0, 1, 3'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 3'd0);
            tick();
        end
        chk("perf_stall5", {16'd0, stall_cnt}, 32'd5);
        chk("perf_bubble3", {16'd0, bubble_cnt}, 32'd3);
        drive(0, 1, 0, 3'd2);
        tick();
        drive(0, 0, 0, 3'd0);
        for (int k = 0; k < 70000; k++) tick();
        chk("perf_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("perf_bubble4", {16'd0, bubble_cnt}, 32'd4);
        drive(1, 0, 1, 3'd0);
        tick();
        chk("perf_flush_clr", {16'd0, stall_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/immediate width.
REQ-002 SHALL have parameter REG_W, default 3, register-ID width.
REQ-003 SHALL have parameter OP_W, default 3, ALU opcode width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port in_valid  input  1  ID stage presents a decoded instruction.
REQ-008 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 SHALL have port ctrl_in  input  6  {writeEnable, memRead, memWrite, branch, ALUSrc, MemToReg}.
REQ-010 SHALL have ports op_in  input  OP_W; rs_val_in, rd_val_in, imm_in  input  DATA_W; rs_in, rd_in  input  REG_W.
REQ-011 SHALL have port out_valid  output  1  EX stage holds a valid instruction.
REQ-012 SHALL have port out_ready  input  1  EX stage consumes this cycle.
REQ-013 SHALL have outputs ctrl_out (6), op_out (OP_W), rs_val_out, rd_val_out, imm_out (DATA_W), rs_out, rd_out (REG_W) mirroring inputs.

Function
REQ-014 SHALL implement a two-entry elastic register: main entry drives outputs, skid entry absorbs one instruction when out_ready drops.
REQ-015 SHALL accept an instruction when in_valid & in_ready & ~flush; accepted data appears on outputs next cycle when main is empty or drained (latency 1).
REQ-016 SHALL drive in_ready = ~skid_valid, from a register only (no combinational path from out_ready).
REQ-017 SHALL transfer out when out_valid & out_ready; skid then moves into main same edge, in order.
REQ-018 SHALL, on simultaneous accept and transfer with empty skid, load new instruction into main with no bubble (full throughput).
REQ-019 SHALL, on accept while main held (out_ready=0), write skid; further in_valid SHALL be refused until skid drains.
REQ-020 SHALL, when flush=1 at an edge, clear main and skid valid bits and ignore in_valid that cycle; flush dominates all other events.
REQ-021 SHALL force ctrl_out to 0 whenever out_valid=0 (bubble has no side effects); data/ID outputs hold last value.
REQ-022 SHALL preserve program order; no entry lost or duplicated under any out_ready pattern.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear out_valid, skid_valid, all output and skid data fields to 0, and drive in_ready=1 after release.
REQ-024 SHALL, on reset mid-transfer, drop held instructions; first cycle after release accepts normally.

Configuration
REQ-025 SHALL, with ID_EX_PERF_EN defined, add outputs stall_cnt and bubble_cnt (16 bits each), saturating at 0xFFFF, cleared by reset and flush.
REQ-026 SHALL count stall_cnt on cycles with out_valid & ~out_ready; bubble_cnt on cycles with out_valid=0.
REQ-027 SHALL, without ID_EX_PERF_EN, omit counters and ports entirely; all other behaviour identical.

Verification
REQ-028 Streaming: in_valid=1, out_ready=1, ops 1,2,3 on consecutive cycles -> outputs 1,2,3 on following consecutive cycles, in_ready stays 1.
REQ-029 Backpressure: out_ready=0 with main=A, send B -> B in skid, in_ready=0, C refused; out_ready=1 -> A then B then C out, none lost.
REQ-030 Flush: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, ctrl_out=6'b0, in_ready=1, flushed input not delivered.
REQ-031 Async reset: reset=0 mid-cycle with out_valid=1, ctrl_out=6'b100001 -> outputs 0 immediately, without clock edge.
REQ-032 Counters (ID_EX_PERF_EN): 5 stalled cycles, 3 empty cycles -> stall_cnt=5, bubble_cnt=3; forced 70000 stalls -> stall_cnt=0xFFFF.
REQ-033 Parameters: DATA_W=16, REG_W=4 -> imm_in=16'hBEEF, rd_in=4'hA appear unchanged after 1 cycle.
